tx_frame_arbiter: RTL and testbench

Round-robin arbiter and frame sequencer that shares one buffered UART transmit path among NUM_REQ requesters. It drives the transmit path's frame-start, byte-strobe and data inputs. It grants one requester at a time, optionally prepends a channel header byte, paces bytes so the 921600-baud serializer is never overrun, and reports frame completion per requester.

---
 rtl/tx_frame_arbiter.sv | 156 +++++++++++++++
 tb/tb_tx_frame_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_arbiter.sv
// Round-robin arbiter and frame sequencer sharing one paced UART transmit path
// among NUM_REQ requesters, with optional per-frame channel header byte.
module tx_frame_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int BYTE_GAP  = 600,
    parameter bit HEADER_EN = 1'b1,
    parameter int LEN_W     = 8
) (
    input  logic                     CLOCK_50M,
    input  logic                     RST,
    input  logic [NUM_REQ-1:0]       Req,
    input  logic [NUM_REQ*LEN_W-1:0] Req_Len,
    input  logic [NUM_REQ*8-1:0]     Req_Data,
    output logic [NUM_REQ-1:0]       Grant,
    output logic [NUM_REQ-1:0]       Byte_Ack,
    output logic [NUM_REQ-1:0]       Frame_Done,
    output logic                     Frame_Start_Sig,
    output logic                     Data_Send_Sig,
    output logic [7:0]               Data,
    output logic                     Busy
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GAP_W = $clog2(BYTE_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(BYTE_GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_winner, w_winner_nxt;
    logic [IDX_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [LEN_W-1:0]   r_remaining, w_remaining_nxt;
    logic [GAP_W-1:0]   r_gap, w_gap_nxt;
    logic               r_hdr_pending, w_hdr_pending_nxt;
    logic [NUM_REQ-1:0] r_grant, w_grant_nxt;

    logic [LEN_W-1:0]   w_len  [NUM_REQ];
    logic [7:0]         w_byte [NUM_REQ];
    logic [NUM_REQ-1:0] w_winner_oh;
    logic [NUM_REQ-1:0] w_pick_oh;
    logic [IDX_W-1:0]   w_pick;
    logic [2:0]         w_chan;
    logic [7:0]         w_header;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign w_len[g]       = Req_Len[g*LEN_W +: LEN_W];
        assign w_byte[g]      = Req_Data[g*8 +: 8];
        assign w_winner_oh[g] = (r_winner == IDX_W'(g));
        assign w_pick_oh[g]   = (w_pick == IDX_W'(g));
    end

    // Scan downward in rotation order so the set bit closest above the pointer wins last.
    always_comb begin : pick_logic
        int idx;
        w_pick = r_rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (Req[IDX_W'(idx)]) w_pick = IDX_W'(idx);
        end
    end

    assign w_chan   = 3'(r_winner);
    assign w_header = {4'hA, 1'b0, w_chan};

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        w_state_nxt       = r_state;
        w_winner_nxt      = r_winner;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_remaining_nxt   = r_remaining;
        w_gap_nxt         = r_gap;
        w_hdr_pending_nxt = r_hdr_pending;
        w_grant_nxt       = r_grant;
        Frame_Start_Sig   = 1'b0;
        Data_Send_Sig     = 1'b0;
        Data              = '0;
        Byte_Ack          = '0;
        Frame_Done        = '0;

        unique case (r_state)
            ST_IDLE: begin
                if (|Req) begin
                    w_winner_nxt    = w_pick;
                    w_remaining_nxt = w_len[w_pick];
                    w_grant_nxt     = w_pick_oh;
                    w_state_nxt     = ST_START;
                end
            end
            ST_START: begin
                Frame_Start_Sig   = 1'b1;
                w_gap_nxt         = GAP_RELOAD;
                w_hdr_pending_nxt = HEADER_EN;
                w_state_nxt       = ST_WAIT;
            end
            ST_WAIT: begin
                // Leaving as the counter hits zero makes each interval exactly BYTE_GAP cycles.
                w_gap_nxt = r_gap - 1'b1;
                if (r_gap <= GAP_W'(1)) begin
                    if (r_hdr_pending || (r_remaining != '0)) w_state_nxt = ST_SEND;
                    else                                       w_state_nxt = ST_DONE;
                end
            end
            ST_SEND: begin
                Data_Send_Sig = 1'b1;
                w_gap_nxt     = GAP_RELOAD;
                w_state_nxt   = ST_WAIT;
                if (r_hdr_pending) begin
                    Data              = w_header;
                    w_hdr_pending_nxt = 1'b0;
                end else if (r_remaining != '0) begin
                    Data            = w_byte[r_winner];
                    Byte_Ack        = w_winner_oh;
                    w_remaining_nxt = r_remaining - 1'b1;
                end
            end
            ST_DONE: begin
                Frame_Done   = w_winner_oh;
                w_grant_nxt  = '0;
                w_rr_ptr_nxt = (r_winner == IDX_W'(NUM_REQ - 1)) ? '0 : r_winner + 1'b1;
                w_state_nxt  = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK_50M or posedge RST) begin
        if (RST) begin
            r_state       <= ST_IDLE;
            r_winner      <= '0;
            r_rr_ptr      <= '0;
            r_remaining   <= '0;
            r_gap         <= '0;
            r_hdr_pending <= 1'b0;
            r_grant       <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_winner      <= w_winner_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_remaining   <= w_remaining_nxt;
            r_gap         <= w_gap_nxt;
            r_hdr_pending <= w_hdr_pending_nxt;
            r_grant       <= w_grant_nxt;
        end
    end

    assign Grant = r_grant;
    assign Busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Bench for tx_frame_arbiter: an event log of the transmit path is compared with
// a frame-level model built from channel order, lengths and byte spacing.
module tb_tx_frame_arbiter;
    localparam int N   = 4;
    localparam int LW  = 8;
    localparam int GAP = 8;
    localparam logic [1:0] K_START = 2'd0, K_SEND = 2'd1, K_DONE = 2'd2, K_ACK = 2'd3;

    typedef struct packed {
        logic [31:0]  cyc;
        logic [1:0]   kind;
        logic [7:0]   data;
        logic [N-1:0] grant;
        logic [N-1:0] ack;
        logic [N-1:0] done;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel_nh = 1'b0;
    always #10 clk = ~clk;

    logic [N-1:0]    req = '0;
    logic [7:0]      cur_byte [N];
    logic [LW-1:0]   len_cfg  [N];
    logic [N*LW-1:0] req_len_bus;
    logic [N*8-1:0]  req_data_bus;
    for (genvar g = 0; g < N; g++) begin : g_bus
        assign req_len_bus[g*LW +: LW] = len_cfg[g];
        assign req_data_bus[g*8 +: 8]  = cur_byte[g];
    end

    logic [N-1:0] a_req, a_grant, a_ack, a_done, b_req, b_grant, b_ack, b_done;
    logic a_start, a_send, a_busy, b_start, b_send, b_busy;
    logic [7:0] a_data, b_data;
    assign a_req = sel_nh ? '0 : req;
    assign b_req = sel_nh ? req : '0;

    tx_frame_arbiter #(.NUM_REQ(N), .BYTE_GAP(GAP), .HEADER_EN(1'b1), .LEN_W(LW)) dut (
        .CLOCK_50M(clk), .RST(rst), .Req(a_req), .Req_Len(req_len_bus), .Req_Data(req_data_bus),
        .Grant(a_grant), .Byte_Ack(a_ack), .Frame_Done(a_done), .Frame_Start_Sig(a_start),
        .Data_Send_Sig(a_send), .Data(a_data), .Busy(a_busy));

    tx_frame_arbiter #(.NUM_REQ(N), .BYTE_GAP(GAP), .HEADER_EN(1'b0), .LEN_W(LW)) dut_nh (
        .CLOCK_50M(clk), .RST(rst), .Req(b_req), .Req_Len(req_len_bus), .Req_Data(req_data_bus),
        .Grant(b_grant), .Byte_Ack(b_ack), .Frame_Done(b_done), .Frame_Start_Sig(b_start),
        .Data_Send_Sig(b_send), .Data(b_data), .Busy(b_busy));

    logic [N-1:0] m_grant, m_ack, m_done;
    logic m_start, m_send;
    logic [7:0] m_data;
    assign m_grant = sel_nh ? b_grant : a_grant;
    assign m_ack   = sel_nh ? b_ack   : a_ack;
    assign m_done  = sel_nh ? b_done  : a_done;
    assign m_start = sel_nh ? b_start : a_start;
    assign m_send  = sel_nh ? b_send  : a_send;
    assign m_data  = sel_nh ? b_data  : a_data;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] chan_bytes [N][256];
    int   frames_left [N];
    int   byte_idx [N];
    bit   drop_on_grant [N];
    ev_t  log_q [$];
    ev_t  exp_q [$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   model_ptr = 0;
    int   nh_ptr = 0;

    function automatic string fmt(input ev_t e);
        return $sformatf("cyc=%0d kind=%0d data=%h grant=%b ack=%b done=%b",
                         e.cyc, e.kind, e.data, e.grant, e.ack, e.done);
    endfunction

    // Event recorder followed by requester behaviour; one process so logging sees pre-update data.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (m_start) log_q.push_back('{cyc: cyc, kind: K_START, data: 8'h00, grant: m_grant, ack: m_ack, done: m_done});
            if (m_send)  log_q.push_back('{cyc: cyc, kind: K_SEND, data: m_data, grant: m_grant, ack: m_ack, done: m_done});
            if (m_done != '0) log_q.push_back('{cyc: cyc, kind: K_DONE, data: 8'h00, grant: '0, ack: m_ack, done: m_done});
            if (m_ack != '0 && !m_send) log_q.push_back('{cyc: cyc, kind: K_ACK, data: 8'h00, grant: m_grant, ack: m_ack, done: m_done});
            for (int ch = 0; ch < N; ch++) begin
                if (m_ack[2'(ch)] && byte_idx[ch] < 255) byte_idx[ch]++;
                if (m_grant[2'(ch)] && drop_on_grant[ch]) req[2'(ch)] = 1'b0;
                if (m_done[2'(ch)]) begin
                    byte_idx[ch] = 0;
                    if (frames_left[ch] > 0) frames_left[ch]--;
                    if (frames_left[ch] == 0) req[2'(ch)] = 1'b0;
                end
                cur_byte[ch] = chan_bytes[ch][8'(byte_idx[ch])];
            end
        end
    end

    // Raise requests and append the frames the arbiter should produce: round-robin order,
    // Start at t, strobes every GAP cycles, Done GAP after the last strobe, next Start two later.
    task automatic launch(input int pend[N], input int lens[N], input bit hdr, inout int ptr,
                          output int first_start, output int last_cyc);
        int left [N];
        int t, c, nb;
        bit found;
        logic [N-1:0] oh;
        logic [7:0] d;
        @(negedge clk);
        for (int ch = 0; ch < N; ch++) begin
            frames_left[ch] = pend[ch];
            left[ch]        = pend[ch];
            len_cfg[ch]     = LW'(lens[ch]);
            byte_idx[ch]    = 0;
            cur_byte[ch]    = chan_bytes[ch][0];
            req[2'(ch)]     = (pend[ch] > 0);
        end
        t = cyc + 1;
        first_start = t;
        last_cyc = cyc;
        found = 1'b1;
        while (found) begin
            found = 1'b0;
            c = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && left[(ptr + k) % N] > 0) begin
                    c = (ptr + k) % N;
                    found = 1'b1;
                end
            end
            if (found) begin
                left[c]--;
                ptr = (c + 1) % N;
                oh = N'(1) << c;
                nb = lens[c] + int'(hdr);
                exp_q.push_back('{cyc: t, kind: K_START, data: 8'h00, grant: oh, ack: '0, done: '0});
                for (int k = 1; k <= nb; k++) begin
                    if (hdr && k == 1) begin
                        d = 8'hA0 | 8'(c);
                        exp_q.push_back('{cyc: t + k*GAP, kind: K_SEND, data: d, grant: oh, ack: '0, done: '0});
                    end else begin
                        d = chan_bytes[c][8'(k - 1 - int'(hdr))];
                        exp_q.push_back('{cyc: t + k*GAP, kind: K_SEND, data: d, grant: oh, ack: oh, done: '0});
                    end
                end
                last_cyc = t + (nb + 1)*GAP;
                exp_q.push_back('{cyc: last_cyc, kind: K_DONE, data: 8'h00, grant: '0, ack: '0, done: oh});
                t = last_cyc + 2;
            end
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc <= c) @(negedge clk);
    endtask

    task automatic fill_random(input int ch);
        for (int k = 0; k < 256; k++) chan_bytes[ch][k] = 8'($urandom);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({a_grant, a_ack, a_done, a_start, a_send, a_data, a_busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: got grant=%b ack=%b done=%b start=%b send=%b data=%h busy=%b, expected all zero",
                     a_grant, a_ack, a_done, a_start, a_send, a_data, a_busy);
        end
        n_cmp++;
        if ({b_grant, b_ack, b_done, b_start, b_send, b_data, b_busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold_nh: got grant=%b busy=%b start=%b, expected all zero", b_grant, b_busy, b_start);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({a_grant, a_busy, a_start, a_send} !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: got grant=%b busy=%b start=%b send=%b, expected all zero", a_grant, a_busy, a_start, a_send);
        end
    endtask

    task automatic test_round_robin();
        int pend [N] = '{2, 1, 1, 1};
        int lens [N] = '{1, 1, 1, 1};
        int fs, last;
        log_q.delete(); exp_q.delete();
        for (int ch = 0; ch < N; ch++) fill_random(ch);
        launch(pend, lens, 1'b1, model_ptr, fs, last);
        wait_until(last + 3);
        n_cmp++;
        if (log_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL rr_count: got %0d events, expected %0d", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_cmp++;
            if (log_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL rr_ev%0d: got %s, expected %s", i, fmt(log_q[i]), fmt(exp_q[i]));
            end
        end
    endtask

    task automatic test_single_frame();
        int pend [N] = '{1, 0, 0, 0};
        int lens [N] = '{3, 0, 0, 0};
        int fs, last;
        log_q.delete(); exp_q.delete();
        chan_bytes[0][0] = 8'h11; chan_bytes[0][1] = 8'h22; chan_bytes[0][2] = 8'h33;
        launch(pend, lens, 1'b1, model_ptr, fs, last);
        wait_until(last + 3);
        n_cmp++;
        if (log_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL single_count: got %0d events, expected %0d", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_cmp++;
            if (log_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL single_ev%0d: got %s, expected %s", i, fmt(log_q[i]), fmt(exp_q[i]));
            end
        end
        n_cmp++;
        if ({a_grant, a_busy} !== '0) begin
            n_fail++; $display("FAIL single_release: got grant=%b busy=%b, expected 0000 0", a_grant, a_busy);
        end
    endtask

    task automatic test_wrap();
        int pend1 [N] = '{0, 1, 0, 0};
        int pend2 [N] = '{1, 1, 0, 0};
        int lens  [N];
        int fs, last;
        log_q.delete(); exp_q.delete();
        for (int ch = 0; ch < N; ch++) begin
            lens[ch] = $urandom_range(2, 0);
            fill_random(ch);
        end
        launch(pend1, lens, 1'b1, model_ptr, fs, last);
        wait_until(last + 3);
        launch(pend2, lens, 1'b1, model_ptr, fs, last);
        wait_until(last + 3);
        n_cmp++;
        if (log_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL wrap_count: got %0d events, expected %0d", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_cmp++;
            if (log_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL wrap_ev%0d: got %s, expected %s", i, fmt(log_q[i]), fmt(exp_q[i]));
            end
        end
    endtask

    task automatic test_random_mix();
        int pend [N];
        int lens [N];
        int fs, last;
        for (int r = 0; r < 4; r++) begin
            log_q.delete(); exp_q.delete();
            for (int ch = 0; ch < N; ch++) begin
                pend[ch] = $urandom_range(2, 0);
                lens[ch] = $urandom_range(4, 0);
                fill_random(ch);
            end
            pend[$urandom_range(N - 1, 0)] = 1 + $urandom_range(1, 0);
            launch(pend, lens, 1'b1, model_ptr, fs, last);
            wait_until(last + 3);
            n_cmp++;
            if (log_q.size() !== exp_q.size()) begin
                n_fail++; $display("FAIL rand%0d_count: got %0d events, expected %0d", r, log_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
                n_cmp++;
                if (log_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL rand%0d_ev%0d: got %s, expected %s", r, i, fmt(log_q[i]), fmt(exp_q[i]));
                end
            end
        end
    endtask

    task automatic test_long_frame();
        int pend [N] = '{0, 1, 0, 0};
        int lens [N] = '{0, 255, 0, 0};
        int fs, last;
        log_q.delete(); exp_q.delete();
        fill_random(1);
        drop_on_grant[1] = 1'b1;
        launch(pend, lens, 1'b1, model_ptr, fs, last);
        wait_until(last + 3);
        drop_on_grant[1] = 1'b0;
        n_cmp++;
        if (log_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL long_count: got %0d events, expected %0d", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_cmp++;
            if (log_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL long_ev%0d: got %s, expected %s", i, fmt(log_q[i]), fmt(exp_q[i]));
            end
        end
    endtask

    task automatic test_no_header();
        int pend1 [N] = '{0, 0, 0, 1};
        int pend2 [N] = '{0, 1, 0, 0};
        int lens  [N] = '{0, 0, 0, 0};
        int fs, last;
        log_q.delete(); exp_q.delete();
        sel_nh = 1'b1;
        fill_random(1);
        launch(pend1, lens, 1'b0, nh_ptr, fs, last);
        wait_until(last + 3);
        lens[1] = $urandom_range(3, 1);
        launch(pend2, lens, 1'b0, nh_ptr, fs, last);
        wait_until(last + 3);
        sel_nh = 1'b0;
        n_cmp++;
        if (log_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL nohdr_count: got %0d events, expected %0d", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_cmp++;
            if (log_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL nohdr_ev%0d: got %s, expected %s", i, fmt(log_q[i]), fmt(exp_q[i]));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int pend0 [N] = '{1, 0, 0, 0};
        int pend2 [N] = '{0, 0, 1, 0};
        int lens  [N] = '{3, 0, 2, 0};
        int fs, last, cut;
        ev_t kept [$];
        log_q.delete(); exp_q.delete();
        fill_random(0);
        fill_random(2);
        launch(pend0, lens, 1'b1, model_ptr, fs, last);
        cut = fs + 2*GAP + GAP/2;
        while (cyc < cut) @(negedge clk);
        n_cmp++;
        if (a_busy !== 1'b1) begin
            n_fail++; $display("FAIL midrst_busy: got busy=%b, expected 1", a_busy);
        end
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if ({a_grant, a_ack, a_done, a_start, a_send, a_data, a_busy} !== '0) begin
            n_fail++;
            $display("FAIL midrst_async: got grant=%b ack=%b done=%b start=%b send=%b data=%h busy=%b, expected all zero",
                     a_grant, a_ack, a_done, a_start, a_send, a_data, a_busy);
        end
        req = '0;
        for (int ch = 0; ch < N; ch++) begin
            frames_left[ch] = 0;
            byte_idx[ch] = 0;
        end
        foreach (exp_q[i]) if (int'(exp_q[i].cyc) < cut) kept.push_back(exp_q[i]);
        exp_q = kept;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
        repeat (2) @(negedge clk);
        launch(pend2, lens, 1'b1, model_ptr, fs, last);
        wait_until(last + 3);
        n_cmp++;
        if (log_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL midrst_count: got %0d events, expected %0d", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_cmp++;
            if (log_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL midrst_ev%0d: got %s, expected %s", i, fmt(log_q[i]), fmt(exp_q[i]));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int ch = 0; ch < N; ch++) begin
            cur_byte[ch]      = 8'h00;
            len_cfg[ch]       = '0;
            frames_left[ch]   = 0;
            byte_idx[ch]      = 0;
            drop_on_grant[ch] = 1'b0;
            for (int k = 0; k < 256; k++) chan_bytes[ch][k] = 8'h00;
        end
        test_reset();
        test_round_robin();
        test_single_frame();
        test_wrap();
        test_random_mix();
        test_long_frame();
        test_no_header();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
